mult_div_sequencer: RTL and testbench

//  Multi-cycle multiply/divide sequencer with HI/LO registers, living in the EX stage beside the ALU.

---
 rtl/mult_div_sequencer_pkg.sv | 40 ++++
 rtl/mult_div_sequencer_result_calc.sv | 78 +++++++
 rtl/mult_div_sequencer.sv | 153 +++++++++++++++
 tb/tb_mult_div_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_sequencer_pkg
//  Purpose  : Shared definitions for the multiply/divide sequencer.
//             Holds the md op-code constants, the sequencer state type and
//             small helper functions used by the top and the result calc.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package mult_div_sequencer_pkg;

  // md op codes presented on mdOpInEX; 6 and 7 are no-ops
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdState_t;

  // True for the four ops that occupy the unit for several cycles
  function automatic logic isMulDiv(input logic [2:0] op);
    return (op <= MD_DIVU);
  endfunction

  // True for DIV/DIVU, which use the longer latency
  function automatic logic isDivide(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : mult_div_sequencer_pkg
`default_nettype wire

// File: rtl/mult_div_sequencer_result_calc.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_sequencer_result_calc
//  Purpose  : Purely combinational HI/LO result for MULT/MULTU/DIV/DIVU.
//             Non-arithmetic op codes produce zero.
//  Ports    : op   in  3   md op code
//             srcA in  32  rs operand (multiplicand / dividend)
//             srcB in  32  rt operand (multiplier / divisor)
//             hi   out 32  upper product word / remainder
//             lo   out 32  lower product word / quotient
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_sequencer_result_calc
  import mult_div_sequencer_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] w_prod;
  logic [31:0] w_absA;
  logic [31:0] w_absB;
  logic [31:0] w_magQ;
  logic [31:0] w_magR;

  always_comb begin
    hi     = '0;
    lo     = '0;
    w_prod = '0;
    w_magQ = '0;
    w_magR = '0;
    // Magnitudes for signed division; 0x80000000 maps onto itself, which is
    // exactly the unsigned magnitude 2^31, so the overflow case needs no
    // special handling: 2^31/1 = 2^31, signs equal -> LO=0x80000000, HI=0.
    w_absA = srcA[31] ? (~srcA + 32'd1) : srcA;
    w_absB = srcB[31] ? (~srcB + 32'd1) : srcB;

    case (op)
      MD_MULT: begin
        w_prod = $signed({{32{srcA[31]}}, srcA}) * $signed({{32{srcB[31]}}, srcB});
        hi     = w_prod[63:32];
        lo     = w_prod[31:0];
      end
      MD_MULTU: begin
        w_prod = {32'd0, srcA} * {32'd0, srcB};
        hi     = w_prod[63:32];
        lo     = w_prod[31:0];
      end
      MD_DIV: begin
        if (srcB == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = srcA;
        end else begin
          w_magQ = w_absA / w_absB;
          w_magR = w_absA % w_absB;
          // Truncate toward zero; remainder follows the dividend's sign
          lo = (srcA[31] ^ srcB[31]) ? (~w_magQ + 32'd1) : w_magQ;
          hi = srcA[31] ? (~w_magR + 32'd1) : w_magR;
        end
      end
      MD_DIVU: begin
        if (srcB == 32'd0) begin
          lo = 32'hFFFF_FFFF;
          hi = srcA;
        end else begin
          lo = srcA / srcB;
          hi = srcA % srcB;
        end
      end
      default: ;
    endcase
  end

endmodule : mult_div_sequencer_result_calc
`default_nettype wire

// File: rtl/mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : mult_div_sequencer
//  Purpose  : Multi-cycle multiply/divide sequencer with HI/LO registers,
//             sitting in EX beside the ALU. The result is computed and
//             latched when the op is accepted, then committed to HI/LO after
//             a fixed latency. Also drives the hazard-unit stall request.
//  Ports    : clk         in   1   clock, rising edge
//             reset       in   1   asynchronous, active-high
//             mdStartInEX in   1   valid md instruction in EX
//             mdOpInEX    in   3   md op code (see package)
//             srcAInEX    in   32  forwarded rs
//             srcBInEX    in   32  forwarded rt
//             mdUseInID   in   1   instruction in ID touches HI/LO
//             busy        out  1   operation in flight
//             mdStall     out  1   freeze request to hazard unit
//             hiOut       out  32  committed HI
//             loOut       out  32  committed LO
//             done        out  1   one-cycle pulse after HI/LO commit
//  Revision : 1.0 - initial release
// ============================================================================
module mult_div_sequencer
  import mult_div_sequencer_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mdStartInEX,
  input  logic [2:0]  mdOpInEX,
  input  logic [31:0] srcAInEX,
  input  logic [31:0] srcBInEX,
  input  logic        mdUseInID,
  output logic        busy,
  output logic        mdStall,
  output logic [31:0] hiOut,
  output logic [31:0] loOut,
  output logic        done
);

  localparam int CNT_W = $clog2(maxInt(MULT_CYCLES, DIV_CYCLES) + 1);
  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] C_LAST      = CNT_W'(1);

  mdState_t          r_state;
  mdState_t          w_stateNext;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_countNext;
  logic [31:0]       r_hi;
  logic [31:0]       w_hiNext;
  logic [31:0]       r_lo;
  logic [31:0]       w_loNext;
  logic [31:0]       r_pendHi;
  logic [31:0]       w_pendHiNext;
  logic [31:0]       r_pendLo;
  logic [31:0]       w_pendLoNext;
  logic              r_done;
  logic              w_doneNext;

  logic [31:0]       w_calcHi;
  logic [31:0]       w_calcLo;
  logic              w_mdStart;

  mult_div_sequencer_result_calc u_resultCalc (
    .op   (mdOpInEX),
    .srcA (srcAInEX),
    .srcB (srcBInEX),
    .hi   (w_calcHi),
    .lo   (w_calcLo)
  );

  assign w_mdStart = mdStartInEX & isMulDiv(mdOpInEX);

  // Stall on any arithmetic start in EX, not only an accepted one: the
  // hazard unit never issues one while busy, and busy covers that case.
  assign busy    = (r_state == BUSY);
  assign mdStall = mdUseInID & (busy | w_mdStart);
  assign hiOut   = r_hi;
  assign loOut   = r_lo;
  assign done    = r_done;

  always_comb begin
    w_stateNext  = r_state;
    w_countNext  = r_count;
    w_hiNext     = r_hi;
    w_loNext     = r_lo;
    w_pendHiNext = r_pendHi;
    w_pendLoNext = r_pendLo;
    w_doneNext   = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_mdStart) begin
          // Result is captured now so later operand changes are irrelevant
          w_stateNext  = BUSY;
          w_countNext  = isDivide(mdOpInEX) ? C_DIV_LOAD : C_MULT_LOAD;
          w_pendHiNext = w_calcHi;
          w_pendLoNext = w_calcLo;
        end else if (mdStartInEX && (mdOpInEX == MD_MTHI)) begin
          w_hiNext = srcAInEX;
        end else if (mdStartInEX && (mdOpInEX == MD_MTLO)) begin
          w_loNext = srcAInEX;
        end
      end
      BUSY: begin
        // Any start while busy is dropped; the unit just keeps counting
        if (r_count == C_LAST) begin
          w_stateNext = IDLE;
          w_countNext = '0;
          w_hiNext    = r_pendHi;
          w_loNext    = r_pendLo;
          w_doneNext  = 1'b1;
        end else begin
          w_countNext = r_count - C_LAST;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_countNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_count  <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_pendHi <= '0;
      r_pendLo <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_count  <= w_countNext;
      r_hi     <= w_hiNext;
      r_lo     <= w_loNext;
      r_pendHi <= w_pendHiNext;
      r_pendLo <= w_pendLoNext;
      r_done   <= w_doneNext;
    end
  end

  // The hazard unit must never present a real md op while one is in flight
  a_noStartWhileBusy : assert property (
    @(posedge clk) disable iff (reset)
      !(busy && mdStartInEX && (mdOpInEX <= MD_MTLO))
  ) else $error("md op presented while sequencer busy");

endmodule : mult_div_sequencer
`default_nettype wire

// File: tb/tb_mult_div_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_div_sequencer
//  Purpose  : Directed self-checking bench for mult_div_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_div_sequencer;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_NOP6  = 3'd6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mdStartInEX = 1'b0;
  logic [2:0]  mdOpInEX = 3'd7;
  logic [31:0] srcAInEX = '0;
  logic [31:0] srcBInEX = '0;
  logic        mdUseInID = 1'b0;
  logic        busy;
  logic        mdStall;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        done;

  int checks = 0;
  int failures = 0;

  mult_div_sequencer #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mdStartInEX (mdStartInEX),
    .mdOpInEX    (mdOpInEX),
    .srcAInEX    (srcAInEX),
    .srcBInEX    (srcBInEX),
    .mdUseInID   (mdUseInID),
    .busy        (busy),
    .mdStall     (mdStall),
    .hiOut       (hiOut),
    .loOut       (loOut),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Present one md op for exactly one edge, then scramble the operands so
  // any late operand sampling shows up in the result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mdOpInEX    = op;
    srcAInEX    = a;
    srcBInEX    = b;
    mdStartInEX = 1'b1;
    @(posedge clk); #1;
    mdStartInEX = 1'b0;
    mdOpInEX    = 3'd7;
    srcAInEX    = $urandom;
    srcBInEX    = $urandom;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, mdStall} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: busy/done/stall=%b expected 000", {busy, done, mdStall});
    end
    checks++;
    if ({hiOut, loOut} !== 64'd0) begin
      failures++;
      $display("FAIL reset_hilo: got %h_%h expected 0_0", hiOut, loOut);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  // Full arithmetic run: HI/LO hold until commit, busy lasts n cycles,
  // done pulses once in the cycle after commit.
  task automatic test_arith_op(input string name, input logic [2:0] op,
                               input logic [31:0] a, input logic [31:0] b, input int n,
                               input logic [31:0] expHi, input logic [31:0] expLo);
    logic [31:0] preHi;
    logic [31:0] preLo;
    int          busyCycles;
    int          overlap;
    preHi = hiOut;
    preLo = loOut;
    busyCycles = 0;
    overlap = 0;
    issue(op, a, b);
    checks++;
    if ({hiOut, loOut} !== {preHi, preLo}) begin
      failures++;
      $display("FAIL %s_early_commit: got %h_%h expected %h_%h", name, hiOut, loOut, preHi, preLo);
    end
    while (busy && busyCycles < n + 4) begin
      busyCycles++;
      if (done) overlap++;
      @(posedge clk); #1;
    end
    checks++;
    if (busyCycles != n || overlap != 0) begin
      failures++;
      $display("FAIL %s_busy: busy cycles %0d (done overlaps %0d) expected %0d (0)", name, busyCycles, overlap, n);
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL %s_done: got %b expected 1", name, done);
    end
    checks++;
    if (hiOut !== expHi) begin
      failures++;
      $display("FAIL %s_hi: got %h expected %h", name, hiOut, expHi);
    end
    checks++;
    if (loOut !== expLo) begin
      failures++;
      $display("FAIL %s_lo: got %h expected %h", name, loOut, expLo);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse: got %b expected 0", name, done);
    end
  endtask

  task automatic test_mthi_mtlo();
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    checks++;
    if ({hiOut, busy, done} !== {32'h1234_5678, 2'b00}) begin
      failures++;
      $display("FAIL mthi: hi/busy/done=%h/%b/%b expected 12345678/0/0", hiOut, busy, done);
    end
    issue(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    checks++;
    if ({hiOut, loOut, busy, done} !== {32'h1234_5678, 32'hCAFE_F00D, 2'b00}) begin
      failures++;
      $display("FAIL mtlo: hi/lo/busy/done=%h/%h/%b/%b expected 12345678/cafef00d/0/0",
               hiOut, loOut, busy, done);
    end
  endtask

  task automatic test_noop();
    issue(OP_NOP6, 32'hDEAD_BEEF, 32'h1);
    issue(3'd7, 32'hDEAD_BEEF, 32'h1);
    checks++;
    if ({hiOut, loOut, busy, done} !== {32'h1234_5678, 32'hCAFE_F00D, 2'b00}) begin
      failures++;
      $display("FAIL noop: hi/lo/busy/done=%h/%h/%b/%b expected 12345678/cafef00d/0/0",
               hiOut, loOut, busy, done);
    end
  endtask

  task automatic test_stall();
    int badStall;
    int cycles;
    badStall = 0;
    cycles = 0;
    // Arithmetic start with HI/LO user in ID: stall in the start cycle itself
    mdUseInID   = 1'b1;
    mdOpInEX    = OP_MULT;
    srcAInEX    = 32'd5;
    srcBInEX    = 32'd6;
    mdStartInEX = 1'b1;
    #1;
    checks++;
    if (mdStall !== 1'b1) begin
      failures++;
      $display("FAIL stall_start: got %b expected 1", mdStall);
    end
    @(posedge clk); #1;
    mdStartInEX = 1'b0;
    while (busy && cycles < 10) begin
      cycles++;
      if (mdStall !== 1'b1) badStall++;
      @(posedge clk); #1;
    end
    checks++;
    if (cycles != 5 || badStall != 0) begin
      failures++;
      $display("FAIL stall_busy: busy cycles %0d unstalled %0d expected 5 and 0", cycles, badStall);
    end
    checks++;
    if ({done, mdStall, loOut} !== {2'b10, 32'd30}) begin
      failures++;
      $display("FAIL stall_done: done/stall/lo=%b/%b/%h expected 1/0/0000001e", done, mdStall, loOut);
    end
    // MTHI does not occupy the unit, so it must not stall ID
    mdOpInEX    = OP_MTHI;
    mdStartInEX = 1'b1;
    #1;
    checks++;
    if (mdStall !== 1'b0) begin
      failures++;
      $display("FAIL stall_mthi: got %b expected 0", mdStall);
    end
    // No HI/LO user in ID: arithmetic start does not stall
    mdStartInEX = 1'b0;
    mdUseInID   = 1'b0;
    mdOpInEX    = OP_DIV;
    mdStartInEX = 1'b1;
    #1;
    checks++;
    if (mdStall !== 1'b0) begin
      failures++;
      $display("FAIL stall_no_user: got %b expected 0", mdStall);
    end
    mdStartInEX = 1'b0;
    mdOpInEX    = 3'd7;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int cycles;
    cycles = 0;
    issue(OP_MULT, 32'd2, 32'd3);
    while (busy && cycles < 10) begin
      cycles++;
      @(posedge clk); #1;
    end
    checks++;
    if ({done, loOut} !== {1'b1, 32'd6}) begin
      failures++;
      $display("FAIL b2b_first: done/lo=%b/%h expected 1/00000006", done, loOut);
    end
    // New start in the done cycle must be accepted
    test_arith_op("b2b_second", OP_MULTU, 32'd4, 32'd5, 5, 32'd0, 32'd20);
  endtask

  task automatic test_reset_mid();
    int sawDone;
    sawDone = 0;
    issue(OP_MULT, 32'h0001_0000, 32'h0003_0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: busy=%b expected 1", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, hiOut, loOut} !== 66'd0) begin
      failures++;
      $display("FAIL rstmid_async: busy/done/hi/lo=%b/%b/%h/%h expected 0/0/0/0", busy, done, hiOut, loOut);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) sawDone++;
    end
    checks++;
    if (sawDone != 0 || {hiOut, loOut} !== 64'd0) begin
      failures++;
      $display("FAIL rstmid_stale: activity %0d hi/lo=%h/%h expected 0 and 0/0", sawDone, hiOut, loOut);
    end
    test_arith_op("rstmid_rerun", OP_MULT, 32'd7, 32'd9, 5, 32'd0, 32'd63);
  endtask

  initial begin
    test_reset();
    test_arith_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,        5,  32'hFFFF_FFFF, 32'hFFFF_FFEB);
    test_arith_op("mult_max",  OP_MULT,  32'h7FFF_FFFF, 32'h7FFF_FFFF, 5, 32'h3FFF_FFFF, 32'h0000_0001);
    test_arith_op("multu",     OP_MULTU, 32'hFFFF_FFFF, 32'd2,        5,  32'h0000_0001, 32'hFFFF_FFFE);
    test_arith_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    test_arith_op("div_negb",  OP_DIV,   32'd7,        32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    test_arith_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    test_arith_op("div_zero",  OP_DIV,   32'hFFFF_FFFB, 32'd0,        10, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
    test_arith_op("divu_zero", OP_DIVU,  32'd7,        32'd0,         10, 32'h0000_0007, 32'hFFFF_FFFF);
    test_arith_op("divu",      OP_DIVU,  32'hFFFF_FFFF, 32'd10,       10, 32'h0000_0005, 32'h1999_9999);
    test_mthi_mtlo();
    test_noop();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_mult_div_sequencer
`default_nettype wire
